proc_ctrl: RTL and testbench

Control unit for the bus-based 16-bit processor. Latches one instruction on `run` and sequences the shared bus, the general-register file and the ALU (operand register A, result register G, tri-state `gout`) over 1–3 steps. Every ALU operation takes the fixed A-load / G-load / G-out sequence. The block drives enables and the ALU mode only; it never carries data.

---
 rtl/proc_pkg.sv | 33 +++
 rtl/proc_ctrl_reg_dec.sv | 16 +
 rtl/proc_ctrl.sv | 118 +++++++++++
 tb/tb_proc_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared encodings for the bus-processor control unit: opcodes, ALU modes,
// FSM states and the instruction-register layout.
package proc_pkg;

  localparam logic [2:0] OP_MOV  = 3'b000;
  localparam logic [2:0] OP_MOVI = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_XOR = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    T1   = 2'd1,
    T2   = 2'd2,
    T3   = 2'd3
  } state_t;

  // Instruction word bits [8:2]; bits [1:0] carry no meaning and are not kept.
  typedef struct packed {
    logic [2:0] op;
    logic [1:0] rx;
    logic [1:0] ry;
  } ir_t;

  function automatic logic is_alu_op(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_XOR);
  endfunction

endpackage

// File: rtl/proc_ctrl_reg_dec.sv
// 2-bit select to NREG-wide one-hot decoder with enable; all zeros when disabled.
module reg_dec #(
  parameter int NREG = 4
) (
  input  logic            en,
  input  logic [1:0]      sel,
  output logic [NREG-1:0] onehot
);

  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      onehot[i] = en && (sel == 2'(i));
    end
  end

endmodule

// File: rtl/proc_ctrl.sv
// Control FSM for the 16-bit bus processor: latches one instruction on run and
// sequences register, immediate, A, G and G-out enables over 1-3 steps.
module proc_ctrl
  import proc_pkg::*;
#(
  parameter int NREG = 4
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            run,
  input  logic [8:0]      instr,
  output logic            irin,
  output logic [NREG-1:0] rin,
  output logic [NREG-1:0] rout,
  // "extern" is a reserved word in SystemVerilog, hence the _en suffix.
  output logic            extern_en,
  output logic            ain,
  output logic            gin,
  output logic            gout,
  output logic [1:0]      ALU_mode,
  output logic            busy,
  output logic            done
);

  state_t     state, state_nxt;
  ir_t        ir;
  logic       accept;
  logic       rin_en, rout_en;
  logic [1:0] rin_sel, rout_sel;
  logic       unused_instr_bits;

  assign unused_instr_bits = ^instr[1:0];
  assign accept            = (state == IDLE) && run;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      ir    <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values regardless of block ordering.
      state <= state_nxt;
      if (accept) ir <= instr[8:2];
    end
  end

  always_comb begin
    // NOTE: every output gets a default before the case so no path can
    // leave a signal unassigned and infer a latch.
    state_nxt = state;
    rin_en    = 1'b0;
    rin_sel   = ir.rx;
    rout_en   = 1'b0;
    rout_sel  = ir.ry;
    extern_en = 1'b0;
    ain       = 1'b0;
    gin       = 1'b0;
    gout      = 1'b0;
    ALU_mode  = ALU_ADD;
    done      = 1'b0;
    unique case (state)
      IDLE: if (run) state_nxt = T1;
      T1: begin
        if (ir.op == OP_MOV) begin
          rout_en   = 1'b1;
          rin_en    = 1'b1;
          done      = 1'b1;
          state_nxt = IDLE;
        end else if (ir.op == OP_MOVI) begin
          extern_en = 1'b1;
          rin_en    = 1'b1;
          done      = 1'b1;
          state_nxt = IDLE;
        end else if (is_alu_op(ir.op)) begin
          rout_en   = 1'b1;
          rout_sel  = ir.rx;
          ain       = 1'b1;
          state_nxt = T2;
        end else begin
          // Invalid opcode: retire in one step with no enables.
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      T2: begin
        rout_en   = 1'b1;
        gin       = 1'b1;
        ALU_mode  = (ir.op == OP_SUB) ? ALU_SUB :
                    (ir.op == OP_XOR) ? ALU_XOR : ALU_ADD;
        state_nxt = T3;
      end
      T3: begin
        gout      = 1'b1;
        rin_en    = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // irin is the only Mealy output; gating with resetn keeps it low during reset.
  assign irin = resetn && accept;
  assign busy = (state != IDLE);

  reg_dec #(.NREG(NREG)) u_rin_dec (
    .en     (rin_en),
    .sel    (rin_sel),
    .onehot (rin)
  );

  reg_dec #(.NREG(NREG)) u_rout_dec (
    .en     (rout_en),
    .sel    (rout_sel),
    .onehot (rout)
  );

endmodule

// File: tb/tb_proc_ctrl.sv
// Scoreboard bench for proc_ctrl: a small bus datapath is driven by the DUT
// enables; an instruction-level reference predicts per-cycle outputs and results.
module tb_proc_ctrl;

  localparam int NREG = 4;

  typedef struct packed {
    logic       irin;
    logic [3:0] rin;
    logic [3:0] rout;
    logic       ext;
    logic       ain;
    logic       gin;
    logic       gout;
    logic [1:0] mode;
    logic       busy;
    logic       done;
  } out_t;

  typedef struct {
    out_t        vec;
    bit          wr;
    int          rx;
    logic [15:0] val;
  } item_t;

  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  logic            run = 1'b0;
  logic [8:0]      instr = '0;
  logic            irin, extern_en, ain, gin, gout, busy, done;
  logic [NREG-1:0] rin, rout;
  logic [1:0]      ALU_mode;

  proc_ctrl #(.NREG(NREG)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .run       (run),
    .instr     (instr),
    .irin      (irin),
    .rin       (rin),
    .rout      (rout),
    .extern_en (extern_en),
    .ain       (ain),
    .gin       (gin),
    .gout      (gout),
    .ALU_mode  (ALU_mode),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Bus datapath driven by the control enables.
  logic [15:0] dp_regs [NREG];
  logic [15:0] a_reg, g_reg, bus, ext_data;
  int          n_drivers;

  always_comb begin
    bus       = '0;
    n_drivers = 0;
    for (int i = 0; i < NREG; i++) begin
      if (rout[i]) begin
        bus       = dp_regs[i];
        n_drivers = n_drivers + 1;
      end
    end
    if (extern_en) begin
      bus       = ext_data;
      n_drivers = n_drivers + 1;
    end
    if (gout) begin
      bus       = g_reg;
      n_drivers = n_drivers + 1;
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < NREG; i++) if (rin[i]) dp_regs[i] <= bus;
    if (ain) a_reg <= bus;
    if (gin) begin
      case (ALU_mode)
        2'b00:   g_reg <= a_reg + bus;
        2'b01:   g_reg <= a_reg - bus;
        2'b10:   g_reg <= a_reg ^ bus;
        default: g_reg <= 'x;
      endcase
    end
  end

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input bit ok, input string name,
                       input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Instruction-level reference: register values plus per-cycle expectations.
  logic [15:0] ref_regs [NREG];
  item_t       exp_q [$];
  int          pred_cnt = 0;

  initial for (int i = 0; i < NREG; i++) ref_regs[i] = '0;

  function automatic out_t busy_vec();
    out_t v = '0;
    v.busy = 1'b1;
    return v;
  endfunction

  task automatic predict(input logic [8:0] w);
    int     op = int'(w[8:6]);
    int     rx = int'(w[5:4]);
    int     ry = int'(w[3:2]);
    item_t  it;
    it.wr  = 1'b0;
    it.rx  = rx;
    it.val = '0;
    case (op)
      0, 1: begin
        it.vec      = busy_vec();
        it.vec.rin  = 4'(1 << rx);
        it.vec.done = 1'b1;
        if (op == 0) it.vec.rout = 4'(1 << ry);
        else         it.vec.ext  = 1'b1;
        it.wr  = 1'b1;
        it.val = (op == 0) ? ref_regs[ry] : ext_data;
        exp_q.push_back(it);
        pred_cnt = 1;
      end
      2, 3, 4: begin
        it.vec      = busy_vec();
        it.vec.rout = 4'(1 << rx);
        it.vec.ain  = 1'b1;
        exp_q.push_back(it);
        it.vec      = busy_vec();
        it.vec.rout = 4'(1 << ry);
        it.vec.gin  = 1'b1;
        it.vec.mode = 2'(op - 2);
        exp_q.push_back(it);
        it.vec      = busy_vec();
        it.vec.gout = 1'b1;
        it.vec.rin  = 4'(1 << rx);
        it.vec.done = 1'b1;
        it.wr       = 1'b1;
        it.val      = (op == 2) ? ref_regs[rx] + ref_regs[ry] :
                      (op == 3) ? ref_regs[rx] - ref_regs[ry] :
                                  ref_regs[rx] ^ ref_regs[ry];
        exp_q.push_back(it);
        pred_cnt = 3;
      end
      default: begin
        it.vec      = busy_vec();
        it.vec.done = 1'b1;
        exp_q.push_back(it);
        pred_cnt = 1;
      end
    endcase
  endtask

  // Predictor: decides at each edge whether an instruction is accepted.
  always @(posedge clk) begin
    if (!resetn) begin
      exp_q.delete();
      pred_cnt = 0;
    end else if (pred_cnt == 0) begin
      if (run) predict(instr);
    end else begin
      pred_cnt--;
    end
  end

  // Monitor: compares every cycle on the falling edge.
  bit          pend_chk = 1'b0;
  int          pend_rx;
  logic [15:0] pend_val;

  always @(negedge clk) begin
    out_t  act, exp;
    item_t it;
    act = {irin, rin, rout, extern_en, ain, gin, gout, ALU_mode, busy, done};
    if (pend_chk) begin
      check(dp_regs[pend_rx] === pend_val, $sformatf("reg_r%0d", pend_rx),
            32'(dp_regs[pend_rx]), 32'(pend_val));
      ref_regs[pend_rx] = pend_val;
      pend_chk = 1'b0;
    end
    if (!resetn) begin
      check(act === '0, "reset_outputs", 32'(act), 32'h0);
      exp_q.delete();
    end else begin
      if (exp_q.size() > 0) begin
        it  = exp_q.pop_front();
        exp = it.vec;
        if (it.wr) begin
          pend_chk = 1'b1;
          pend_rx  = it.rx;
          pend_val = it.val;
        end
      end else begin
        exp      = '0;
        exp.irin = run;
      end
      check(act === exp, "outputs", 32'(act), 32'(exp));
    end
    check(n_drivers <= 1, "bus_drivers", 32'(n_drivers), 32'd1);
  end

  task automatic issue(input logic [2:0] op, input logic [1:0] rx,
                       input logic [1:0] ry, input logic [15:0] ext);
    instr    = {op, rx, ry, 2'($urandom)};
    ext_data = ext;
    run      = 1'b1;
    @(posedge clk);
    #1;
    run   = 1'b0;
    instr = 9'($urandom);
    repeat (4) begin
      @(posedge clk);
      #1;
      instr = 9'($urandom);
    end
  endtask

  initial begin
    ext_data = '0;
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;

    // Abort an add in T2, then a movi must still work.
    instr = {3'b010, 2'd0, 2'd1, 2'b00};
    run   = 1'b1;
    @(posedge clk); #1;
    run = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    issue(3'b001, 2'd0, 2'd0, 16'd5);

    issue(3'b001, 2'd1, 2'd0, 16'd11);
    issue(3'b001, 2'd2, 2'd0, 16'd7);
    issue(3'b001, 2'd3, 2'd0, 16'd9);
    issue(3'b000, 2'd1, 2'd2, 16'h0);       // mov r1,r2 -> 7
    issue(3'b001, 2'd0, 2'd0, 16'd2);
    issue(3'b001, 2'd1, 2'd0, 16'd3);
    issue(3'b010, 2'd0, 2'd1, 16'h0);       // add -> 5
    issue(3'b011, 2'd0, 2'd1, 16'h0);       // sub -> 2
    issue(3'b001, 2'd2, 2'd0, 16'hAA8F);
    issue(3'b001, 2'd3, 2'd0, 16'h558F);
    issue(3'b100, 2'd2, 2'd3, 16'h0);       // xor -> FF00
    issue(3'b110, 2'd1, 2'd2, 16'h0);       // invalid
    issue(3'b010, 2'd1, 2'd1, 16'h0);       // add r1,r1 -> 6

    // run held high, mov and add alternating, instr changing every cycle.
    run = 1'b1;
    for (int i = 0; i < 12; i++) begin
      instr = {(i % 2 == 0) ? 3'b000 : 3'b010, 6'($urandom)};
      @(posedge clk); #1;
    end
    run = 1'b0;
    repeat (4) begin @(posedge clk); #1; end

    // Random traffic over every opcode with constant external data.
    ext_data = 16'($urandom);
    for (int i = 0; i < 400; i++) begin
      run   = 1'($urandom_range(0, 1));
      instr = 9'($urandom);
      @(posedge clk); #1;
    end
    run = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    check(exp_q.size() == 0, "drain", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
